// File: rtl/cmd_reg_bank_if.sv
`default_nettype none
// =============================================================================
// cmd_reg_bank_if : host register bus (write/read enables, word address, data)
// Rev 1.0
// =============================================================================
interface cmd_reg_bank_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic [DATA_W-1:0] din;
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dout;

  modport master (output din, we, re, addr, input dout);
  modport slave  (input din, we, re, addr, output dout);
endinterface
`default_nettype wire

// File: rtl/cmd_reg_bank.sv
`default_nettype none
// =============================================================================
// cmd_reg_bank : host command register bank (control/status/event/scratch).
// Optional feature macro: SHADOW_COMMIT_EN (shadowed control words + commit reg)
// Rev 1.0
// =============================================================================
module cmd_reg_bank #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int N_CTRL = 4,
  parameter int N_STAT = 2,
  parameter int N_EVT  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cmd_reg_bank_if.slave            bus,
  output logic [N_CTRL*DATA_W-1:0] ctrl_out,
  output logic [N_CTRL-1:0]        ctrl_upd,
  input  logic [N_STAT*DATA_W-1:0] stat_in,
  input  logic [N_EVT-1:0]         evt_in,
  output logic                     sync_en,
  input  logic                     sync_in
);

  localparam int c_S0     = N_CTRL;
  localparam int c_E0     = c_S0 + N_STAT;
  localparam int c_SYNC   = c_E0 + N_EVT;
  localparam int c_DEPTH  = 2 ** ADDR_W;
  localparam int c_COMMIT = c_DEPTH - 1;
  localparam logic [DATA_W-1:0] c_CNT_MAX = '1;

  if (N_CTRL + N_STAT + N_EVT > c_DEPTH - 1) begin : g_param_check
    $error("cmd_reg_bank: N_CTRL+N_STAT+N_EVT exceeds 2^ADDR_W-1");
  end

  logic [DATA_W-1:0] r_ctrl    [N_CTRL];
  logic [DATA_W-1:0] w_ctrl_rd [N_CTRL];
  logic [N_CTRL-1:0] r_upd;
  logic              r_sync_en;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] r_ram [c_DEPTH];
  logic              w_is_scratch;
  logic              w_ram_we;
  logic [N_CTRL-1:0] w_ctrl_wr;

  // Counter index N_EVT is the sync-count word; it shares the event logic.
  logic [DATA_W-1:0] r_cnt [N_EVT+1];
  logic [N_EVT:0]    w_evt_all;
  logic [N_EVT:0]    r_evt_d;
  logic [N_EVT:0]    w_rise;
  logic [N_EVT:0]    w_cnt_clr;

  assign w_evt_all = {sync_in, evt_in};
  assign w_rise    = w_evt_all & ~r_evt_d;

  always_comb begin
    w_ctrl_wr = '0;
    w_cnt_clr = '0;
    for (int i = 0; i < N_CTRL; i++) begin
      w_ctrl_wr[i] = bus.we && (bus.addr == ADDR_W'(i));
    end
    for (int k = 0; k <= N_EVT; k++) begin
      w_cnt_clr[k] = bus.we && (bus.addr == ADDR_W'(c_E0 + k));
    end
  end

`ifdef SHADOW_COMMIT_EN
  logic [DATA_W-1:0] r_shadow [N_CTRL];
  logic              w_commit;

  assign w_commit     = bus.we && (bus.addr == ADDR_W'(c_COMMIT)) && bus.din[0];
  assign w_is_scratch = (bus.addr > ADDR_W'(c_SYNC)) && (bus.addr != ADDR_W'(c_COMMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CTRL; i++) r_shadow[i] <= '0;
    end else begin
      for (int i = 0; i < N_CTRL; i++) begin
        if (w_ctrl_wr[i]) r_shadow[i] <= bus.din;
      end
    end
  end

  for (genvar i = 0; i < N_CTRL; i++) begin : g_ctrl_rd
    assign w_ctrl_rd[i] = r_shadow[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CTRL; i++) r_ctrl[i] <= '0;
      r_upd     <= '0;
      r_sync_en <= 1'b0;
    end else begin
      r_sync_en <= r_ctrl[0][0];
      if (w_commit) begin
        for (int i = 0; i < N_CTRL; i++) r_ctrl[i] <= r_shadow[i];
        r_upd <= '1;
      end else begin
        r_upd <= '0;
      end
    end
  end
`else
  assign w_is_scratch = bus.addr > ADDR_W'(c_SYNC);

  for (genvar i = 0; i < N_CTRL; i++) begin : g_ctrl_rd
    assign w_ctrl_rd[i] = r_ctrl[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CTRL; i++) r_ctrl[i] <= '0;
      r_upd     <= '0;
      r_sync_en <= 1'b0;
    end else begin
      r_sync_en <= r_ctrl[0][0];
      for (int i = 0; i < N_CTRL; i++) begin
        if (w_ctrl_wr[i]) r_ctrl[i] <= bus.din;
      end
      r_upd <= w_ctrl_wr;
    end
  end
`endif

  for (genvar i = 0; i < N_CTRL; i++) begin : g_ctrl_out
    assign ctrl_out[i*DATA_W +: DATA_W] = r_ctrl[i];
  end
  assign ctrl_upd = r_upd;
  assign sync_en  = r_sync_en;

  // A clear that coincides with a new edge keeps that edge as the first count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_d <= '0;
      for (int k = 0; k <= N_EVT; k++) r_cnt[k] <= '0;
    end else begin
      r_evt_d <= w_evt_all;
      for (int k = 0; k <= N_EVT; k++) begin
        if (w_cnt_clr[k]) begin
          r_cnt[k] <= w_rise[k] ? DATA_W'(1) : '0;
        end else if (w_rise[k] && (r_cnt[k] != c_CNT_MAX)) begin
          r_cnt[k] <= r_cnt[k] + DATA_W'(1);
        end
      end
    end
  end

  assign w_ram_we = bus.we && w_is_scratch;

  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[bus.addr] <= bus.din;
  end

  // Read mux sees pre-edge state, which gives read-before-write for free.
  always_comb begin
    w_rdata = '0;
    if (w_is_scratch) w_rdata = r_ram[bus.addr];
    for (int i = 0; i < N_CTRL; i++) begin
      if (bus.addr == ADDR_W'(i)) w_rdata = w_ctrl_rd[i];
    end
    for (int i = 0; i < N_STAT; i++) begin
      if (bus.addr == ADDR_W'(c_S0 + i)) w_rdata = stat_in[i*DATA_W +: DATA_W];
    end
    for (int k = 0; k <= N_EVT; k++) begin
      if (bus.addr == ADDR_W'(c_E0 + k)) w_rdata = r_cnt[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
    end else if (bus.re) begin
      r_dout <= w_rdata;
    end
  end

  assign bus.dout = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_cmd_reg_bank.sv
`default_nettype none
// =============================================================================
// tb_cmd_reg_bank : directed self-checking bench for cmd_reg_bank
// Rev 1.0
// =============================================================================
module tb_cmd_reg_bank;

  localparam int c_E0   = 6;
  localparam int c_SYNC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] ctrl_out;
  logic [3:0]  ctrl_upd;
  logic [31:0] stat_in;
  logic [3:0]  evt_in;
  logic        sync_en;
  logic        sync_in;

  logic [31:0] ctrl_out8;
  logic [3:0]  ctrl_upd8;
  logic [15:0] stat_in8;
  logic [3:0]  evt_in8;
  logic        sync_en8;
  logic        sync_in8;

  int n_tests = 0;
  int n_fail  = 0;

  cmd_reg_bank_if #(.DATA_W(16), .ADDR_W(5)) bus ();
  cmd_reg_bank_if #(.DATA_W(8),  .ADDR_W(5)) bus8 ();

  cmd_reg_bank #(.DATA_W(16), .ADDR_W(5), .N_CTRL(4), .N_STAT(2), .N_EVT(4)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ctrl_out (ctrl_out),
    .ctrl_upd (ctrl_upd),
    .stat_in  (stat_in),
    .evt_in   (evt_in),
    .sync_en  (sync_en),
    .sync_in  (sync_in)
  );

  // Narrow instance so counter saturation is reachable in a short run.
  cmd_reg_bank #(.DATA_W(8), .ADDR_W(5), .N_CTRL(4), .N_STAT(2), .N_EVT(4)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus8),
    .ctrl_out (ctrl_out8),
    .ctrl_upd (ctrl_upd8),
    .stat_in  (stat_in8),
    .evt_in   (evt_in8),
    .sync_en  (sync_en8),
    .sync_in  (sync_in8)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    bus.we   = 1'b1;
    bus.addr = a;
    bus.din  = d;
    step();
    bus.we   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [15:0] exp);
    bus.re   = 1'b1;
    bus.addr = a;
    step();
    bus.re   = 1'b0;
    check(tag, {16'h0, bus.dout}, {16'h0, exp});
  endtask

  task automatic rd8_chk(input string tag, input logic [4:0] a, input logic [7:0] exp);
    bus8.re   = 1'b1;
    bus8.addr = a;
    step();
    bus8.re   = 1'b0;
    check(tag, {24'h0, bus8.dout}, {24'h0, exp});
  endtask

  task automatic pulse_evt(input int k);
    evt_in[k] = 1'b1;
    step();
    evt_in[k] = 1'b0;
    step();
  endtask

  task automatic pulse_evt8();
    evt_in8[0] = 1'b1;
    step();
    evt_in8[0] = 1'b0;
    step();
  endtask

  initial begin
    bus.din = '0; bus.we = 1'b0; bus.re = 1'b0; bus.addr = '0;
    bus8.din = '0; bus8.we = 1'b0; bus8.re = 1'b0; bus8.addr = '0;
    stat_in = '0; evt_in = '0; sync_in = 1'b0;
    stat_in8 = '0; evt_in8 = '0; sync_in8 = 1'b0;

    // Reset held while inputs toggle
    repeat (6) begin
      {bus.we, bus.re, evt_in, sync_in} = 7'($urandom);
      bus.addr = 5'($urandom);
      bus.din  = 16'($urandom);
      stat_in  = $urandom;
      step();
    end
    check("rst_ctrl_lo", ctrl_out[31:0], 32'h0);
    check("rst_ctrl_hi", ctrl_out[63:32], 32'h0);
    check("rst_upd", {28'h0, ctrl_upd}, 32'h0);
    check("rst_sync_en", {31'h0, sync_en}, 32'h0);
    check("rst_dout", {16'h0, bus.dout}, 32'h0);

    bus.we = 1'b0; bus.re = 1'b0; bus.addr = '0; bus.din = '0;
    evt_in = '0; sync_in = 1'b0; stat_in = '0;
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_dout", {16'h0, bus.dout}, 32'h0);
    rd_chk("rst_evt0", 5'(c_E0), 16'h0000);

`ifndef SHADOW_COMMIT_EN
    // Direct control writes
    wr(5'd0, 16'h0001);
    check("ctrl0_val", {16'h0, ctrl_out[15:0]}, 32'h0001);
    check("ctrl0_upd", {28'h0, ctrl_upd}, 32'h1);
    check("sync_en_lag", {31'h0, sync_en}, 32'h0);
    step();
    check("ctrl0_upd_end", {28'h0, ctrl_upd}, 32'h0);
    check("sync_en_set", {31'h0, sync_en}, 32'h1);
    rd_chk("ctrl0_read", 5'd0, 16'h0001);
    wr(5'd2, 16'hA5A5);
    check("ctrl2_val", {16'h0, ctrl_out[47:32]}, 32'hA5A5);
    check("ctrl2_upd", {28'h0, ctrl_upd}, 32'h4);
    check("ctrl0_keep", {16'h0, ctrl_out[15:0]}, 32'h0001);
`else
    // Shadowed control writes and commit
    wr(5'd1, 16'h00AA);
    check("shd_ctrl1_hold", {16'h0, ctrl_out[31:16]}, 32'h0);
    check("shd_upd_quiet", {28'h0, ctrl_upd}, 32'h0);
    rd_chk("shd_read1", 5'd1, 16'h00AA);
    wr(5'd31, 16'h0000);
    check("shd_nocommit", {16'h0, ctrl_out[31:16]}, 32'h0);
    wr(5'd31, 16'h0001);
    check("shd_commit_val", {16'h0, ctrl_out[31:16]}, 32'h00AA);
    check("shd_commit_upd", {28'h0, ctrl_upd}, 32'hF);
    step();
    check("shd_commit_upd_end", {28'h0, ctrl_upd}, 32'h0);
    rd_chk("shd_commit_read", 5'd31, 16'h0000);
`endif

    // Event counter 1: three short pulses plus one long high
    repeat (3) pulse_evt(1);
    evt_in[1] = 1'b1;
    repeat (5) step();
    evt_in[1] = 1'b0;
    step();
    rd_chk("evt1_count", 5'(c_E0 + 1), 16'd4);
    rd_chk("evt0_idle", 5'(c_E0), 16'd0);
    evt_in[1] = 1'b1;
    wr(5'(c_E0 + 1), 16'h5555);
    evt_in[1] = 1'b0;
    step();
    rd_chk("evt1_clr_edge", 5'(c_E0 + 1), 16'd1);
    bus.re = 1'b1; bus.we = 1'b1; bus.addr = 5'(c_E0 + 1);
    step();
    bus.re = 1'b0; bus.we = 1'b0;
    check("evt1_rbw", {16'h0, bus.dout}, 32'd1);
    rd_chk("evt1_cleared", 5'(c_E0 + 1), 16'd0);

    // Status words are read-only snapshots
    stat_in = {16'hCAFE, 16'hBEEF};
    wr(5'd4, 16'h1234);
    rd_chk("stat0", 5'd4, 16'hBEEF);
    rd_chk("stat1", 5'd5, 16'hCAFE);

    // Sync-count word
    sync_in = 1'b1; step(); sync_in = 1'b0; step();
    sync_in = 1'b1; step(); sync_in = 1'b0; step();
    sync_in = 1'b1; repeat (3) step(); sync_in = 1'b0; step();
    rd_chk("sync_count", 5'(c_SYNC), 16'd3);

    // Scratch RAM
    wr(5'd20, 16'h1357);
    rd_chk("scratch_rd", 5'd20, 16'h1357);
    bus.re = 1'b1; bus.we = 1'b1; bus.addr = 5'd20; bus.din = 16'h2468;
    step();
    bus.re = 1'b0; bus.we = 1'b0;
    check("scratch_rbw", {16'h0, bus.dout}, 32'h1357);
    rd_chk("scratch_new", 5'd20, 16'h2468);
    repeat (3) step();
    check("dout_hold", {16'h0, bus.dout}, 32'h2468);
`ifndef SHADOW_COMMIT_EN
    wr(5'd31, 16'h0F0F);
    rd_chk("scratch_top", 5'd31, 16'h0F0F);
`endif

    // Saturation on the 8-bit instance
    repeat (254) pulse_evt8();
    rd8_chk("sat_pre", 5'(c_E0), 8'hFE);
    repeat (3) pulse_evt8();
    rd8_chk("sat_max", 5'(c_E0), 8'hFF);

    // Reset asserted mid-access
    wr(5'd0, 16'h0003);
    bus.re = 1'b1; bus.addr = 5'd20;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", ctrl_out[31:0], 32'h0);
    check("mid_rst_dout", {16'h0, bus.dout}, 32'h0);
    check("mid_rst_sync_en", {31'h0, sync_en}, 32'h0);
    check("mid_rst_upd", {28'h0, ctrl_upd}, 32'h0);
    bus.re = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    rd_chk("mid_rst_sync_cnt", 5'(c_SYNC), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
